// File: rtl/alu_op_sequencer.sv
// Issue stage for an 8-bit combinational ALU: small register file, command
// handshake, registered ALU operands and flagged writeback of the ALU result.
module alu_op_sequencer #(
    parameter int W    = 8,
    parameter int NREG = 4,
    parameter int AW   = 2
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [2:0]    cmd_op,
    input  logic [AW-1:0] cmd_ra,
    input  logic [AW-1:0] cmd_rb,
    input  logic [AW-1:0] cmd_rd,
    input  logic          cmd_imm_en,
    input  logic [W-1:0]  cmd_imm,

    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [W-1:0]  wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [W-1:0]  rd_data,

    output logic [2:0]    alu_sel,
    output logic [W-1:0]  alu_a,
    output logic [W-1:0]  alu_b,
    input  logic [W-1:0]  alu_y,

    output logic          done,
    output logic [W-1:0]  res,
    output logic          zero,
    output logic          neg
);

    typedef enum logic {
        IDLE = 1'b0,
        EXEC = 1'b1
    } state_t;

    state_t          state;
    logic [W-1:0]    regs [NREG];
    logic [AW-1:0]   rd_q;

    assign cmd_ready = (state == IDLE);
    assign rd_data   = regs[rd_addr];

    // The EXEC writeback is assigned after the host write, so on an address
    // clash the ALU result wins; operands are sampled from pre-edge contents.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
            rd_q    <= '0;
            alu_sel <= '0;
            alu_a   <= '0;
            alu_b   <= '0;
            res     <= '0;
            zero    <= 1'b0;
            neg     <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (wr_en) begin
                regs[wr_addr] <= wr_data;
            end
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        alu_sel <= cmd_op;
                        alu_a   <= regs[cmd_ra];
                        alu_b   <= cmd_imm_en ? cmd_imm : regs[cmd_rb];
                        rd_q    <= cmd_rd;
                        state   <= EXEC;
                    end
                end
                EXEC: begin
                    regs[rd_q] <= alu_y;
                    res        <= alu_y;
                    zero       <= (alu_y == '0);
                    neg        <= alu_y[W-1];
                    done       <= 1'b1;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Issue stage directly upstream of the 8-bit combinational ALU (3-bit select: 0 zero, 1 AND, 2 OR, 3 XOR, 4 NOT a, 5 a-b, 6 a+b, 7 FFh).
- Holds a small register file and accepts operation commands over a valid/ready handshake.
- Drives the ALU's sel/a/b inputs from registers, captures the ALU result, and writes it back to a destination register with zero/negative flags.
- Allows multi-step ALU sequences (load, operate, chain) without external glue.

Parameters:
- W, 8, datapath width; must equal the ALU width (8).
- NREG, 4, number of general registers.
- AW, 2, register address width (log2 NREG).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  sequencer can accept a command.
- cmd_op  in  3  ALU operation, ALU select encoding.
- cmd_ra  in  AW  source register for ALU a.
- cmd_rb  in  AW  source register for ALU b.
- cmd_rd  in  AW  destination register.
- cmd_imm_en  in  1  when 1, ALU b takes cmd_imm instead of reg[cmd_rb].
- cmd_imm  in  W  immediate operand.
- wr_en  in  1  host direct register load.
- wr_addr  in  AW  host load address.
- wr_data  in  W  host load data.
- rd_addr  in  AW  host read address.
- rd_data  out  W  reg[rd_addr], combinational.
- alu_sel  out  3  to ALU sel, registered.
- alu_a  out  W  to ALU a, registered.
- alu_b  out  W  to ALU b, registered.
- alu_y  in  W  from ALU y, combinational result.
- done  out  1  one-cycle pulse: result written.
- res  out  W  last written-back result.
- zero  out  1  res == 0.
- neg  out  1  res[W-1].

Behaviour:
- Reset (async, any state): FSM to IDLE. All regs, alu_sel, alu_a, alu_b, res, zero, neg and done go to 0. cmd_ready=1 once rst deasserts.
- FSM states: IDLE, EXEC.
- IDLE:
  - cmd_ready=1.
  - On an edge with cmd_valid=1: latch alu_sel<=cmd_op, alu_a<=reg[cmd_ra], alu_b<=(cmd_imm_en ? cmd_imm : reg[cmd_rb]), rd_q<=cmd_rd; go to EXEC.
- EXEC:
  - cmd_ready=0. The ALU sees stable registered operands for the full cycle.
  - On the next edge: reg[rd_q]<=alu_y, res<=alu_y, zero<=(alu_y==0), neg<=alu_y[W-1], done<=1; go to IDLE.
- Timing:
  - Command accepted at edge N.
  - ALU inputs valid after N.
  - Writeback at edge N+1.
  - done high during cycle N+1..N+2.
  - cmd_ready high again in that same cycle.
  - Maximum throughput is one command per 2 cycles.
  - A command held valid is accepted on the first edge with cmd_ready=1.
- done is high for exactly one cycle per writeback; otherwise 0.
- Arithmetic wraps modulo 2^W; the ALU performs it, the sequencer applies no carry or overflow handling.
- alu_sel, alu_a and alu_b hold their last values while IDLE; they are never cleared except by reset.
- Host writes (wr_en) are accepted in any state.
  - Same edge as writeback, same address: the writeback wins and the host write is dropped.
  - Different addresses: both take effect.
- A host write to a source register during EXEC does not affect the in-flight operation, because operands are already latched.
- Source operands read the register file as of before the accept edge. A host write on the same accept edge is not seen by that command.
- rd_data reflects register state after the last edge; there is no bypass.
- cmd_ra = cmd_rb = cmd_rd is legal; the old value is read and the new value written.
- Reset asserted during EXEC aborts the operation: no writeback, no done.

Test Plan:
- Load r0=AAh, r1=F0h; cmd op=1, ra=0, rb=1, rd=2 -> next cycle alu_sel=1, alu_a=AAh, alu_b=F0h; then r2=A0h, res=A0h, neg=1, zero=0, done pulses once.
- Load r0=10h, r1=20h; op=5, ra=0, rb=1, rd=3 -> r3=F0h (wrap), neg=1. Then op=6 with r0=r1=80h -> result 00h, zero=1, neg=0.
- Immediate: r0=AAh; op=3, ra=0, imm_en=1, imm=FFh, rd=0 -> r0=55h. Then op=4, ra=0, rd=1 -> r1=AAh; op=7 -> FFh; op=0 -> 00h, zero=1.
- Hold cmd_valid high with two commands -> accepts exactly 2 cycles apart, cmd_ready pattern 1,0,1,0, done pulses 2 cycles apart.
- Host wr_en to r2 (55h) on the writeback edge of an op targeting r2 producing A0h -> r2=A0h. Same case with wr_addr=1 -> r1=55h and r2=A0h.
- Assert rst mid-EXEC -> no done, all regs and outputs 0 immediately (asynchronously), cmd_ready=1 after release, and the next command executes normally.
